mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_if.sv | 27 ++
 rtl/mult_div_unit.sv | 143 ++++++++++++++
 tb/tb_mult_div_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - operation/result bundle between the pipeline and the multiply/divide unit
//
// Purpose: groups the operation request (MdOp, A, B) and the unit's
// status/result outputs (busy, done, HI, LO) into one interface.
// Signals:
//   MdOp [3:0]  operation select (0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo)
//   A    [31:0] rs operand
//   B    [31:0] rt operand
//   busy        operation in flight
//   done        one-cycle pulse when HI/LO first show a new mult/div result
//   HI   [31:0] current HI register
//   LO   [31:0] current LO register
// Modports: master drives the request, slave (the unit) drives status/results.
interface mult_div_unit_if;
  logic [3:0]  MdOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output MdOp, output A, output B,
                  input busy, input done, input HI, input LO);
  modport slave  (input MdOp, input A, input B,
                  output busy, output done, output HI, output LO);
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
//
// Purpose: accepts mult/multu/div/divu in IDLE, computes the result at once
// into shadow registers, then holds busy for MULT_CYCLES/DIV_CYCLES cycles
// before committing to HI/LO with a one-cycle done pulse. mthi/mtlo write
// HI/LO directly from A in IDLE. All ops are ignored while busy.
// Ports:
//   clk    input  rising-edge clock
//   reset  input  synchronous, active-low reset
//   mdu    slave modport of mult_div_unit_if (MdOp, A, B in; busy, done, HI, LO out)
// Parameters: MULT_CYCLES (default 5), DIV_CYCLES (default 10).
// Optional feature: define MDU_DIV0_GUARD_EN to finish div/divu by zero after
// a single busy cycle leaving HI/LO unchanged; otherwise divide-by-zero runs
// the full DIV_CYCLES and yields HI=A, LO=0xFFFFFFFF.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave mdu
);
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      shi_q, shi_d, slo_q, slo_d;
  logic             wr_q, wr_d;     // shadow is committed on completion
  logic             done_q, done_d;

  logic [31:0] a, b;
  assign a = mdu.A;
  assign b = mdu.B;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed division through magnitudes so 0x80000000 / -1 wraps to 0x80000000
  // instead of overflowing. Divisor forced to 1 when zero to keep the divider defined.
  logic [31:0] abs_a, abs_b, div_b, uq, ur, sq, sr;
  assign abs_a = a[31] ? (~a + 32'd1) : a;
  assign abs_b = b[31] ? (~b + 32'd1) : b;
  assign div_b = (b == 32'd0) ? 32'd1 : b;
  logic [31:0] sdiv_b;
  assign sdiv_b = (b == 32'd0) ? 32'd1 : abs_b;
  logic [31:0] mq, mr;
  assign mq = abs_a / sdiv_b;
  assign mr = abs_a % sdiv_b;
  assign sq = (a[31] ^ b[31]) ? (~mq + 32'd1) : mq;
  assign sr = a[31] ? (~mr + 32'd1) : mr;
  assign uq = a / div_b;
  assign ur = a % div_b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    shi_d   = shi_q;
    slo_d   = slo_q;
    wr_d    = wr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        case (mdu.MdOp)
          4'd1, 4'd2: begin
            shi_d   = (mdu.MdOp == 4'd1) ? prod_s[63:32] : prod_u[63:32];
            slo_d   = (mdu.MdOp == 4'd1) ? prod_s[31:0]  : prod_u[31:0];
            wr_d    = 1'b1;
            cnt_d   = CNT_W'(MULT_CYCLES);
            state_d = MULT;
          end
          4'd3, 4'd4: begin
            state_d = DIV;
            cnt_d   = CNT_W'(DIV_CYCLES);
            wr_d    = 1'b1;
            if (b == 32'd0) begin
`ifdef MDU_DIV0_GUARD_EN
              cnt_d = CNT_W'(1);
              wr_d  = 1'b0;
`else
              shi_d = a;
              slo_d = 32'hFFFF_FFFF;
`endif
            end else begin
              shi_d = (mdu.MdOp == 4'd3) ? sr : ur;
              slo_d = (mdu.MdOp == 4'd3) ? sq : uq;
            end
          end
          4'd5:    hi_d = a;
          4'd6:    lo_d = a;
          default: ;
        endcase
      end
      MULT, DIV: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          if (wr_q) begin
            hi_d = shi_q;
            lo_d = slo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      shi_q   <= '0;
      slo_q   <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      shi_q   <= shi_d;
      slo_q   <= slo_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
    end
  end

  assign mdu.busy = (state_q != IDLE);
  assign mdu.done = done_q;
  assign mdu.HI   = hi_q;
  assign mdu.LO   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
module tb_mult_div_unit;
  logic clk;
  logic reset;
  mult_div_unit_if mdu ();

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Drives op at the current negedge; returns at the negedge after completion.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int ncyc, output logic got_done, output logic held,
                        output logic done_at_issue);
    logic [31:0] h0, l0;
    h0 = mdu.HI;
    l0 = mdu.LO;
    mdu.MdOp = op;
    mdu.A    = a;
    mdu.B    = b;
    @(negedge clk);
    done_at_issue = mdu.done;
    mdu.MdOp = 4'd0;
    ncyc = 0;
    held = 1'b1;
    while (mdu.busy && ncyc < 64) begin
      if (mdu.HI !== h0 || mdu.LO !== l0) held = 1'b0;
      ncyc++;
      @(negedge clk);
    end
    got_done = mdu.done;
  endtask

  vec_t vecs[9];
  exp_t e;
  int   ncyc;
  logic got_done, held, dai, seen_done;
  logic [31:0] ph, pl;

  initial begin
    vecs[0] = '{4'd1, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
    vecs[1] = '{4'd2, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[2] = '{4'd3, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{4'd4, 32'd7,         32'd2,          32'd1,         32'd3,         10};
    vecs[4] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, 10};
    vecs[5] = '{4'd1, 32'd3,         32'hFFFF_FFFC,  32'hFFFF_FFFF, 32'hFFFF_FFF4, 5};
    vecs[6] = '{4'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE,  32'hFFFF_FFFF, 32'd3,         10};
    vecs[7] = '{4'd3, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, 10};
    vecs[8] = '{4'd2, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'd0,         5};

    reset    = 1'b0;
    mdu.MdOp = 4'd0;
    mdu.A    = '0;
    mdu.B    = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, mdu.busy}, 32'd0);
    chk("reset_done", {31'd0, mdu.done}, 32'd0);
    chk("reset_hi", mdu.HI, 32'd0);
    chk("reset_lo", mdu.LO, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Back-to-back issue: each op is driven at the negedge where done is seen.
    for (int i = 0; i < 9; i++) begin
      sb.push_back('{vecs[i].hi, vecs[i].lo, vecs[i].cyc});
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, ncyc, got_done, held, dai);
      e = sb.pop_front();
      chk($sformatf("v%0d_hi", i), mdu.HI, e.hi);
      chk($sformatf("v%0d_lo", i), mdu.LO, e.lo);
      chk($sformatf("v%0d_busy_cycles", i), ncyc, e.cyc);
      chk($sformatf("v%0d_done", i), {31'd0, got_done}, 32'd1);
      chk($sformatf("v%0d_hold", i), {31'd0, held}, 32'd1);
      chk($sformatf("v%0d_done_pulse", i), {31'd0, dai}, 32'd0);
    end

    // divu with mthi on busy cycle 3 and on the completion edge: both ignored.
    mdu.MdOp = 4'd4; mdu.A = 32'd7; mdu.B = 32'd2;
    @(negedge clk);
    mdu.MdOp = 4'd0;
    repeat (2) @(negedge clk);
    mdu.MdOp = 4'd5; mdu.A = 32'h1234;
    @(negedge clk);
    mdu.MdOp = 4'd0;
    chk("mthi_busy_hi", mdu.HI, 32'h4000_0000);
    repeat (6) @(negedge clk);
    chk("divu_busy_last", {31'd0, mdu.busy}, 32'd1);
    mdu.MdOp = 4'd5; mdu.A = 32'h5555;
    @(negedge clk);
    mdu.MdOp = 4'd0;
    chk("divu_done", {31'd0, mdu.done}, 32'd1);
    chk("divu_hi", mdu.HI, 32'd1);
    chk("divu_lo", mdu.LO, 32'd3);
    @(negedge clk);
    chk("compl_edge_ignored_hi", mdu.HI, 32'd1);
    chk("compl_edge_busy", {31'd0, mdu.busy}, 32'd0);

    // mthi in IDLE, then reset during a multu.
    mdu.MdOp = 4'd5; mdu.A = 32'hABCD;
    @(negedge clk);
    mdu.MdOp = 4'd0;
    chk("mthi_hi", mdu.HI, 32'hABCD);
    chk("mthi_busy", {31'd0, mdu.busy}, 32'd0);
    chk("mthi_done", {31'd0, mdu.done}, 32'd0);
    mdu.MdOp = 4'd2; mdu.A = 32'd3; mdu.B = 32'd4;
    @(negedge clk);
    mdu.MdOp = 4'd0;
    @(negedge clk);
    reset = 1'b0;
    mdu.MdOp = 4'd6; mdu.A = 32'h9999;
    @(negedge clk);
    reset = 1'b1;
    mdu.MdOp = 4'd0;
    chk("rst_mid_hi", mdu.HI, 32'd0);
    chk("rst_mid_lo", mdu.LO, 32'd0);
    chk("rst_mid_busy", {31'd0, mdu.busy}, 32'd0);
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (mdu.done) seen_done = 1'b1;
    end
    chk("rst_no_done", {31'd0, seen_done}, 32'd0);
    chk("rst_discard_lo", mdu.LO, 32'd0);

    // mtlo, then divide by zero.
    mdu.MdOp = 4'd6; mdu.A = 32'h77;
    @(negedge clk);
    mdu.MdOp = 4'd0;
    chk("mtlo_lo", mdu.LO, 32'h77);
    ph = mdu.HI;
    pl = mdu.LO;
`ifdef MDU_DIV0_GUARD_EN
    sb.push_back('{ph, pl, 1});
`else
    sb.push_back('{32'd5, 32'hFFFF_FFFF, 10});
`endif
    run_op(4'd3, 32'd5, 32'd0, ncyc, got_done, held, dai);
    e = sb.pop_front();
    chk("div0_hi", mdu.HI, e.hi);
    chk("div0_lo", mdu.LO, e.lo);
    chk("div0_busy_cycles", ncyc, e.cyc);
    chk("div0_done", {31'd0, got_done}, 32'd1);
    chk("div0_hold", {31'd0, held}, 32'd1);
    @(negedge clk);
    chk("div0_done_pulse", {31'd0, mdu.done}, 32'd0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
